psa_simd_pipe: RTL and testbench



---
 rtl/psa_pkg.sv | 14 +
 rtl/psa_simd_pipe_if.sv | 30 +++
 rtl/psa_sat_alu.sv | 39 +++
 rtl/psa_simd_pipe.sv | 81 ++++++++
 tb/tb_psa_simd_pipe.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psa_pkg.sv
// psa_pkg: lane-size encoding and shared constants for the SIMD saturating add/sub pipe.
package psa_pkg;
    typedef enum logic [1:0] {
        MODE_4    = 2'b00,
        MODE_8    = 2'b01,
        MODE_FULL = 2'b10
    } mode_e;
    localparam int NIB_W = 4;
    localparam int N_LSZ = 3;
    // Reserved encoding 11 falls back to 4-bit lanes.
    function automatic logic [1:0] lane_sel(input logic [1:0] mode);
        return mode == MODE_8 ? 2'd1 : mode == MODE_FULL ? 2'd2 : 2'd0;
    endfunction
endpackage

// File: rtl/psa_simd_pipe_if.sv
// psa_simd_pipe_if: operand/result handshake and status bundle of the SIMD saturating pipe.
interface psa_simd_pipe_if
    import psa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   sub;
    logic [1:0]             mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       sum;
    logic [WIDTH/NIB_W-1:0] lane_ovfl;
    logic                   error;
    logic                   err_clr;
    logic                   err_sticky;
    logic [CNT_W-1:0]       sat_cnt;
    modport master (
        output in_valid, a, b, sub, mode, out_ready, err_clr,
        input  in_ready, out_valid, sum, lane_ovfl, error, err_sticky, sat_cnt
    );
    modport slave (
        input  in_valid, a, b, sub, mode, out_ready, err_clr,
        output in_ready, out_valid, sum, lane_ovfl, error, err_sticky, sat_cnt
    );
endinterface

// File: rtl/psa_sat_alu.sv
// psa_sat_alu: per-lane two's complement add/sub with lane-isolated carries and saturation.
module psa_sat_alu
    import psa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   sub,
    input  logic [1:0]             mode,
    output logic [WIDTH-1:0]       sum,
    output logic [WIDTH/NIB_W-1:0] lane_ovfl,
    output logic                   error
);
    localparam int NL = WIDTH / NIB_W;
    logic [N_LSZ-1:0][WIDTH-1:0] res;
    logic [N_LSZ-1:0][NL-1:0]    ovf;
    logic [1:0]                  sel;
    // Every lane size is computed in parallel; isolated slices keep carries inside a lane.
    for (genvar s = 0; s < N_LSZ; s++) begin : g_sz
        localparam int L = s == 0 ? NIB_W : s == 1 ? 2 * NIB_W : WIDTH;
        for (genvar i = 0; i < WIDTH / L; i++) begin : g_lane
            logic [L-1:0] x;
            logic [L-1:0] y;
            logic [L-1:0] r;
            logic         o;
            assign x = a[i*L +: L];
            assign y = b[i*L +: L];
            assign r = sub ? x - y : x + y;
            assign o = (sub ? x[L-1] != y[L-1] : x[L-1] == y[L-1]) && r[L-1] != x[L-1];
            assign res[s][i*L +: L] = o ? {x[L-1], {(L-1){~x[L-1]}}} : r;
            assign ovf[s][i*L/NIB_W +: L/NIB_W] = {(L/NIB_W){o}};
        end
    end
    assign sel       = lane_sel(mode);
    assign sum       = res[sel];
    assign lane_ovfl = ovf[sel];
    assign error     = |lane_ovfl;
endmodule

// File: rtl/psa_simd_pipe.sv
// psa_simd_pipe: two-stage valid/ready pipe around the saturating lane ALU with error statistics.
module psa_simd_pipe
    import psa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    psa_simd_pipe_if.slave bus
);
    logic                   s1_valid;
    logic                   s2_valid;
    logic                   adv1;
    logic                   adv2;
    logic                   fire;
    logic [WIDTH-1:0]       s1_a;
    logic [WIDTH-1:0]       s1_b;
    logic                   s1_sub;
    logic [1:0]             s1_mode;
    logic [WIDTH-1:0]       alu_sum;
    logic [WIDTH/NIB_W-1:0] alu_ovfl;
    logic                   alu_err;
    assign adv2          = !s2_valid || bus.out_ready;
    assign adv1          = !s1_valid || adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid;
    assign fire          = s2_valid && bus.out_ready && bus.error;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sub   <= 1'b0;
            s1_mode  <= MODE_4;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a    <= bus.a;
                s1_b    <= bus.b;
                s1_sub  <= bus.sub;
                s1_mode <= bus.mode;
            end
        end
    end
    psa_sat_alu #(.WIDTH(WIDTH)) u_alu (
        .a(s1_a),
        .b(s1_b),
        .sub(s1_sub),
        .mode(s1_mode),
        .sum(alu_sum),
        .lane_ovfl(alu_ovfl),
        .error(alu_err)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            bus.sum       <= '0;
            bus.lane_ovfl <= '0;
            bus.error     <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.sum       <= alu_sum;
                bus.lane_ovfl <= alu_ovfl;
                bus.error     <= alu_err;
            end
        end
    end
    // A consumed error beat wins over a simultaneous clear: sticky stays set, count restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err_sticky <= 1'b0;
            bus.sat_cnt    <= '0;
        end else begin
            bus.err_sticky <= fire || (bus.err_sticky && !bus.err_clr);
            bus.sat_cnt    <= fire ? (bus.err_clr ? CNT_W'(1) : bus.sat_cnt + CNT_W'(~&bus.sat_cnt))
                                   : bus.err_clr ? '0 : bus.sat_cnt;
        end
    end
endmodule

// File: tb/tb_psa_simd_pipe.sv
// tb_psa_simd_pipe: scoreboard bench with an arithmetic lane model for psa_simd_pipe.
module tb_psa_simd_pipe;
    import psa_pkg::*;
    localparam int W  = 16;
    localparam int NL = W / 4;
    typedef struct packed {
        logic [W-1:0]  sum;
        logic [NL-1:0] ovfl;
        logic          err;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    psa_simd_pipe_if #(.WIDTH(W), .CNT_W(8)) bus ();
    psa_simd_pipe #(.WIDTH(W), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_acc = 0;
    logic m_st = 1'b0;
    int   m_cnt = 0;
    logic hold = 1'b0;
    exp_t held;
    exp_t cur;
    exp_t pe;
    logic fire_m;
    logic tog_en = 1'b0;
    int   base;
    exp_t ov_e;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic [NL-1:0] o, input logic e);
        exp_t r;
        r.sum = s;
        r.ovfl = o;
        r.err = e;
        return r;
    endfunction

    // Lanes as signed integers: exact sum, clamp to the lane range, report which lanes clamped.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [1:0] m);
        exp_t e;
        int l, mask, lo, hi, x, y, r;
        l = m == 2'b01 ? 8 : m == 2'b10 ? W : 4;
        mask = (1 << l) - 1;
        lo = -(1 << (l - 1));
        hi = (1 << (l - 1)) - 1;
        e = '0;
        for (int k = 0; k < W / l; k++) begin
            x = (int'(a) >> (k * l)) & mask;
            y = (int'(b) >> (k * l)) & mask;
            if (x > hi) x -= 1 << l;
            if (y > hi) y -= 1 << l;
            r = s ? x - y : x + y;
            if (r > hi || r < lo) begin
                e.ovfl |= NL'(((1 << (l / 4)) - 1) << (k * l / 4));
                r = r > hi ? hi : lo;
            end
            e.sum |= W'((r & mask) << (k * l));
        end
        e.err = |e.ovfl;
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [1:0] m, input exp_t e);
        bit acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (tog_en) begin
                bus.out_ready = $urandom_range(0, 2) != 0;
                bus.err_clr = $urandom_range(0, 9) == 0;
            end
            bus.in_valid = 1'b1;
            bus.a = a;
            bus.b = b;
            bus.sub = s;
            bus.mode = m;
            #1 acc = bus.in_ready;
            @(posedge clk);
        end
        if (acc) begin
            q.push_back(e);
            n_acc++;
        end else chk("accept_timeout", 0, 1);
    endtask

    task automatic send_rand();
        logic [W-1:0] a, b;
        logic s;
        logic [1:0] m;
        a = W'($urandom);
        b = W'($urandom);
        s = 1'($urandom_range(0, 1));
        m = 2'($urandom_range(0, 3));
        send(a, b, s, m, model(a, b, s, m));
    endtask

    task automatic idle();
        @(negedge clk);
        if (tog_en) begin
            bus.out_ready = $urandom_range(0, 2) != 0;
            bus.err_clr = $urandom_range(0, 9) == 0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    // Monitor: samples just before each rising edge, pops on consumption, tracks sticky/counter.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            q.delete();
            m_st = 1'b0;
            m_cnt = 0;
            hold = 1'b0;
        end else begin
            chk("err_sticky", bus.err_sticky, m_st);
            chk("sat_cnt", bus.sat_cnt, m_cnt);
            cur = mk(bus.sum, bus.lane_ovfl, bus.error);
            if (hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", cur, held);
            end
            fire_m = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    pe = q.pop_front();
                    chk("beat_sum", bus.sum, pe.sum);
                    chk("beat_ovfl", bus.lane_ovfl, pe.ovfl);
                    chk("beat_err", bus.error, pe.err);
                    fire_m = pe.err;
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            held = cur;
            if (fire_m) begin
                m_st = 1'b1;
                m_cnt = bus.err_clr ? 1 : m_cnt == 255 ? 255 : m_cnt + 1;
            end else if (bus.err_clr) begin
                m_st = 1'b0;
                m_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.mode = MODE_4;
        bus.out_ready = 1'b0;
        bus.err_clr = 1'b0;
        ov_e = mk(16'h7777, 4'hF, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_sum", bus.sum, 0);
        chk("rst_ovfl", bus.lane_ovfl, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_sticky", bus.err_sticky, 0);
        chk("rst_cnt", bus.sat_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        // Nibble lanes all saturate; output appears exactly two edges after accept.
        send(16'h7777, 16'h1111, 1'b0, MODE_4, ov_e);
        idle();
        #1 chk("lat_early", bus.out_valid, 0);
        @(negedge clk);
        #1 chk("lat_two", bus.out_valid, 1);
        drain();
        send(16'h7F80, 16'h0180, 1'b0, MODE_8, mk(16'h7F80, 4'hF, 1'b1));
        send(16'h1020, 16'h0101, 1'b0, MODE_8, mk(16'h1121, 4'h0, 1'b0));
        send(16'h8000, 16'h0001, 1'b1, MODE_FULL, mk(16'h8000, 4'hF, 1'b1));
        send(16'h0005, 16'h0003, 1'b1, MODE_FULL, mk(16'h0002, 4'h0, 1'b0));
        idle();
        drain();
        // Backpressure: two beats fill the pipe, the third is refused until out_ready returns.
        @(negedge clk);
        bus.out_ready = 1'b0;
        base = n_acc;
        send(16'h1234, 16'h1111, 1'b0, MODE_4, model(16'h1234, 16'h1111, 1'b0, MODE_4));
        send(16'h4000, 16'h5000, 1'b0, MODE_FULL, model(16'h4000, 16'h5000, 1'b0, MODE_FULL));
        @(negedge clk);
        bus.a = 16'h0F0F;
        bus.b = 16'h7171;
        bus.sub = 1'b1;
        bus.mode = MODE_8;
        #1;
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_accepted", n_acc - base, 2);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_still_blocked", bus.in_ready, 0);
        chk("bp_held_sum", bus.sum, model(16'h1234, 16'h1111, 1'b0, MODE_4).sum);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        send(16'h0F0F, 16'h7171, 1'b1, MODE_8, model(16'h0F0F, 16'h7171, 1'b1, MODE_8));
        idle();
        drain();
        // Clear coinciding with a consumed error beat, then clear alone, then counter saturation.
        send(16'h7777, 16'h1111, 1'b0, MODE_4, ov_e);
        idle();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        #1;
        chk("clr_set_sticky", bus.err_sticky, 1);
        chk("clr_set_cnt", bus.sat_cnt, 1);
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        chk("clr_sticky", bus.err_sticky, 0);
        chk("clr_cnt", bus.sat_cnt, 0);
        for (int i = 0; i < 300; i++) send(16'h7777, 16'h1111, 1'b0, MODE_4, ov_e);
        idle();
        drain();
        chk("cnt_saturated", bus.sat_cnt, 8'hFF);
        chk("cnt_sticky", bus.err_sticky, 1);
        // Reset with two error beats in flight: nothing survives.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(16'h7777, 16'h1111, 1'b0, MODE_4, ov_e);
        send(16'h8000, 16'h0001, 1'b1, MODE_FULL, mk(16'h8000, 4'hF, 1'b1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_sticky", bus.err_sticky, 0);
        chk("mid_rst_cnt", bus.sat_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("post_rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("no_stale_beat", bus.out_valid, 0);
        end
        // Randomized traffic with random backpressure and clears.
        tog_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send_rand();
        end
        tog_en = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.err_clr = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
